mem_slot_arbiter: RTL and testbench
===================================

# mem_slot_arbiter

- Time-division arbiter sharing the single SDRAM port between the Z80 CPU, the video fetcher and the disc/printer DMA engine, plus SDRAM refresh.
- Sequenced by the system clock-enable strobes: each 4 MHz CPU period is split into four 16 MHz slots, each owned by one requester.
- Sits between the requesters and the SDRAM command interface.
- Guarantees the CPU a fixed-latency slot every CPU cycle regardless of video or DMA load.

## Interface
- `AW`, default 23: memory address width (byte address).
- `DW`, default 8: data width.
- `REFRESH_INTERVAL`, default 15: number of CPU periods between refresh commands (range 1..255).

- `clk` input 1: system clock; the 16 MHz slot strobe is one `clk` in four.
- `reset_n` input 1: asynchronous, active-low reset.
- `slot_ce` input 1: 16 MHz clock-enable pulse that marks a slot boundary.
- `frame_sync` input 1: 4 MHz CPU positive-phase clock-enable; always coincides with a `slot_ce`.
- `cpu_req`, `cpu_we` input 1: CPU access request (level) and write flag.
- `cpu_addr` input AW, `cpu_din` input DW: CPU access address and write data.
- `cpu_dout` output DW, `cpu_ack` output 1: CPU read data and completion pulse.
- `vid_req` input 1, `vid_addr` input AW: video read request; video is read-only.
- `vid_dout` output DW, `vid_ack` output 1: video read data and completion pulse.
- `dma_req`, `dma_we` input 1, `dma_addr` input AW, `dma_din` input DW: DMA access request, write flag, address and write data.
- `dma_dout` output DW, `dma_ack` output 1: DMA read data and completion pulse.
- `mem_start` output 1: one-cycle command strobe to the SDRAM controller.
- `mem_we`, `mem_refresh` output 1: command type flags.
- `mem_addr` output AW, `mem_wdata` output DW: command address and write data.
- `mem_rdata` input DW, `mem_done` input 1: SDRAM read data and completion pulse; read data is valid with `mem_done`.
- `overrun` output 1: one-cycle pulse when a slot is skipped because the previous access has not completed.

## Operation
- **Slot index**
  - 2-bit `slot`. On `slot_ce`: if `frame_sync`, `slot` <= 0; otherwise `slot` <= `slot` + 1, wrapping 3 to 0.
  - `frame_sync` without `slot_ce` is ignored.
- **Slot owners**
  - 0 = CPU, 1 = video, 2 = DMA, 3 = refresh.
- **Refresh counter**
  - 8-bit counter, incremented on every `frame_sync & slot_ce`.
  - When it equals `REFRESH_INTERVAL`-1 it sets `refresh_pending` and wraps to 0.
  - `refresh_pending` clears when a refresh command is issued.
- **State machine** `IDLE`, `WAIT`; reset state is `IDLE`.
  - `IDLE`, on `slot_ce` when the slot owner is eligible (owner's `req`=1, or `refresh_pending` for slot 3): latch the owner ID and register the command onto the `mem_*` outputs, pulse `mem_start` for 1 cycle, go to `WAIT`.
  - `IDLE`, on `slot_ce` with no eligible owner: remain in `IDLE`.
  - `WAIT`, on `mem_done`: copy `mem_rdata` into the latched owner's `*_dout` (reads only; writes and refresh leave the dout unchanged), pulse that owner's `*_ack` for 1 cycle, go to `IDLE`.
  - `WAIT`, on `slot_ce` without `mem_done`: pulse `overrun`. The slot is lost, no command is issued, and `slot` still advances.
  - `slot_ce` and `mem_done` in the same cycle in `WAIT`: complete the access only, go to `IDLE`. The new slot is lost and `overrun` is not pulsed.
- **Requester rules**
  - `req`, `addr`, `we` and `din` are held stable until `ack`.
  - A `req` dropped after the request has been sampled still completes and still acks.
  - `req` is sampled in the `slot_ce` cycle.
- `*_dout` hold their value until the next read ack for that port.
- **Reset mid-access**: asserting `reset_n` low clears all state immediately. The in-flight access is abandoned and no ack is issued.

## Timing
- **Reset values**: `cpu_ack`, `vid_ack`, `dma_ack`, `mem_start`, `mem_we`, `mem_refresh`, `overrun` = 0. `mem_addr`, `mem_wdata`, all `*_dout` = 0. `slot` = 0, refresh counter = 0, `refresh_pending` = 0.
- `mem_start` is asserted in the cycle after the sampling `slot_ce`.
- Ack is asserted in the cycle after `mem_done`, and `*_dout` is valid in that same ack cycle.
- **Latency**: `slot_ce` to ack = 2 + SDRAM latency, where SDRAM latency counts from `mem_start` to `mem_done`.
- Worst-case CPU latency from request to its next slot is 4 slot periods.
- `mem_*` command fields are stable from `mem_start` until `mem_done`.

## Configuration
- **`SLOT_DONATE_EN`**
  - **Defined**: an `IDLE` slot whose owner is not eligible is donated. Priority is CPU > DMA > video, and refresh is never donated to. The ack goes to the actual user of the slot.
  - **Undefined**: strict fixed time-division; unused slots stay empty.

## Test plan
- **Fixed CPU access**: `cpu_req`=1, `cpu_we`=0, `cpu_addr`=0x012345, SDRAM returns 0xA5 with 2-cycle latency. Required: `mem_start` the cycle after the slot-0 `slot_ce`, `mem_addr`=0x012345, `cpu_ack` 3 cycles after `mem_start` with `cpu_dout`=0xA5.
- **All requesters busy**: CPU, video and DMA all requesting continuously. Required: `mem_start` order CPU, video, DMA every CPU period; refresh every 15th period in slot 3; no `overrun`.
- **Slow memory**: `mem_done` delayed by 6 cycles on a CPU access. Required: `overrun` pulses at the slot-1 `slot_ce`, video is served in slot 1 of the next period, `slot` sequence is unbroken.
- **Donation** (with `SLOT_DONATE_EN`): only `dma_req`=1, write 0x3C to 0x000100. Required: DMA issued in slot 0 and `dma_ack` pulses. Without the macro: issued only in slot 2.
- **Reset mid-access**: drop `reset_n` low while in `WAIT` for a CPU read. Required: all outputs 0 asynchronously; after release no `cpu_ack` for the abandoned access, and `slot` restarts at 0.

Source files
------------

// File: rtl/mem_slot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_slot_arbiter
//  Purpose  : Time-division arbiter for the single SDRAM port. Each 4 MHz CPU
//             period is split into four 16 MHz slots owned by CPU (0),
//             video (1), DMA (2) and refresh (3). One command is in flight at
//             a time; a slot that arrives while a command is still pending is
//             lost and flagged on overrun.
//  Ports    : clk, reset_n          - clock, asynchronous active-low reset
//             slot_ce, frame_sync   - slot strobe, period-start strobe
//             cpu_*                 - CPU request/write/addr/data, dout, ack
//             vid_*                 - video read request/addr, dout, ack
//             dma_*                 - DMA request/write/addr/data, dout, ack
//             mem_*                 - SDRAM command out, read data/done in
//             overrun               - pulse when a slot is skipped
//  Options  : SLOT_DONATE_EN - when defined, a slot whose owner is idle is
//             given to another requester (CPU > DMA > video); refresh never
//             takes a donated slot.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_slot_arbiter #(
    parameter int AW               = 23,
    parameter int DW               = 8,
    parameter int REFRESH_INTERVAL = 15
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          slot_ce,
    input  logic          frame_sync,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_ack,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_dout,
    output logic          vid_ack,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_din,
    output logic [DW-1:0] dma_dout,
    output logic          dma_ack,
    output logic          mem_start,
    output logic          mem_we,
    output logic          mem_refresh,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_done,
    output logic          overrun
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] c_own_cpu      = 2'd0;
    localparam logic [1:0] c_own_vid      = 2'd1;
    localparam logic [1:0] c_own_dma      = 2'd2;
    localparam logic [1:0] c_own_ref      = 2'd3;
    localparam logic [7:0] c_refresh_last = 8'(REFRESH_INTERVAL - 1);

    state_t        state_q, state_d;
    logic [1:0]    slot_q, slot_d;
    logic [1:0]    owner_q, owner_d;
    logic [7:0]    refresh_cnt_q, refresh_cnt_d;
    logic          refresh_pending_q, refresh_pending_d;
    logic          mem_start_q, mem_start_d;
    logic          mem_we_q, mem_we_d;
    logic          mem_refresh_q, mem_refresh_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          vid_ack_q, vid_ack_d;
    logic          dma_ack_q, dma_ack_d;
    logic [DW-1:0] cpu_dout_q, cpu_dout_d;
    logic [DW-1:0] vid_dout_q, vid_dout_d;
    logic [DW-1:0] dma_dout_q, dma_dout_d;
    logic          overrun_q, overrun_d;

    logic [1:0]    w_slot_next;
    logic [1:0]    w_grant;
    logic          w_grant_valid;

    // Slot being entered at this slot_ce; arbitration looks at this slot,
    // not the one that is ending.
    always_comb begin
        w_slot_next = frame_sync ? 2'd0 : slot_q + 2'd1;
        slot_d      = slot_ce ? w_slot_next : slot_q;
    end

    always_comb begin
        w_grant       = w_slot_next;
        w_grant_valid = 1'b0;
        case (w_slot_next)
            c_own_cpu: w_grant_valid = cpu_req;
            c_own_vid: w_grant_valid = vid_req;
            c_own_dma: w_grant_valid = dma_req;
            default:   w_grant_valid = refresh_pending_q;
        endcase
`ifdef SLOT_DONATE_EN
        if (!w_grant_valid) begin
            if (cpu_req) begin
                w_grant       = c_own_cpu;
                w_grant_valid = 1'b1;
            end else if (dma_req) begin
                w_grant       = c_own_dma;
                w_grant_valid = 1'b1;
            end else if (vid_req) begin
                w_grant       = c_own_vid;
                w_grant_valid = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        state_d           = state_q;
        owner_d           = owner_q;
        refresh_cnt_d     = refresh_cnt_q;
        refresh_pending_d = refresh_pending_q;
        mem_start_d       = 1'b0;
        mem_we_d          = mem_we_q;
        mem_refresh_d     = mem_refresh_q;
        mem_addr_d        = mem_addr_q;
        mem_wdata_d       = mem_wdata_q;
        cpu_ack_d         = 1'b0;
        vid_ack_d         = 1'b0;
        dma_ack_d         = 1'b0;
        cpu_dout_d        = cpu_dout_q;
        vid_dout_d        = vid_dout_q;
        dma_dout_d        = dma_dout_q;
        overrun_d         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (slot_ce && w_grant_valid) begin
                    owner_d     = w_grant;
                    mem_start_d = 1'b1;
                    state_d     = ST_WAIT;
                    case (w_grant)
                        c_own_cpu: begin
                            mem_we_d      = cpu_we;
                            mem_refresh_d = 1'b0;
                            mem_addr_d    = cpu_addr;
                            mem_wdata_d   = cpu_din;
                        end
                        c_own_vid: begin
                            mem_we_d      = 1'b0;
                            mem_refresh_d = 1'b0;
                            mem_addr_d    = vid_addr;
                        end
                        c_own_dma: begin
                            mem_we_d      = dma_we;
                            mem_refresh_d = 1'b0;
                            mem_addr_d    = dma_addr;
                            mem_wdata_d   = dma_din;
                        end
                        default: begin
                            mem_we_d          = 1'b0;
                            mem_refresh_d     = 1'b1;
                            refresh_pending_d = 1'b0;
                        end
                    endcase
                end
            end
            default: begin
                // Completion wins over a coinciding slot boundary: that slot
                // is simply lost without an overrun report.
                if (mem_done) begin
                    state_d = ST_IDLE;
                    case (owner_q)
                        c_own_cpu: begin
                            cpu_ack_d = 1'b1;
                            if (!mem_we_q) cpu_dout_d = mem_rdata;
                        end
                        c_own_vid: begin
                            vid_ack_d  = 1'b1;
                            vid_dout_d = mem_rdata;
                        end
                        c_own_dma: begin
                            dma_ack_d = 1'b1;
                            if (!mem_we_q) dma_dout_d = mem_rdata;
                        end
                        default: begin
                        end
                    endcase
                end else if (slot_ce) begin
                    overrun_d = 1'b1;
                end
            end
        endcase

        // Period counter; setting pending takes precedence over a clear in
        // the same cycle so a refresh is never dropped.
        if (slot_ce && frame_sync) begin
            if (refresh_cnt_q == c_refresh_last) begin
                refresh_cnt_d     = 8'd0;
                refresh_pending_d = 1'b1;
            end else begin
                refresh_cnt_d = refresh_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= ST_IDLE;
            slot_q            <= 2'd0;
            owner_q           <= 2'd0;
            refresh_cnt_q     <= 8'd0;
            refresh_pending_q <= 1'b0;
            mem_start_q       <= 1'b0;
            mem_we_q          <= 1'b0;
            mem_refresh_q     <= 1'b0;
            mem_addr_q        <= '0;
            mem_wdata_q       <= '0;
            cpu_ack_q         <= 1'b0;
            vid_ack_q         <= 1'b0;
            dma_ack_q         <= 1'b0;
            cpu_dout_q        <= '0;
            vid_dout_q        <= '0;
            dma_dout_q        <= '0;
            overrun_q         <= 1'b0;
        end else begin
            state_q           <= state_d;
            slot_q            <= slot_d;
            owner_q           <= owner_d;
            refresh_cnt_q     <= refresh_cnt_d;
            refresh_pending_q <= refresh_pending_d;
            mem_start_q       <= mem_start_d;
            mem_we_q          <= mem_we_d;
            mem_refresh_q     <= mem_refresh_d;
            mem_addr_q        <= mem_addr_d;
            mem_wdata_q       <= mem_wdata_d;
            cpu_ack_q         <= cpu_ack_d;
            vid_ack_q         <= vid_ack_d;
            dma_ack_q         <= dma_ack_d;
            cpu_dout_q        <= cpu_dout_d;
            vid_dout_q        <= vid_dout_d;
            dma_dout_q        <= dma_dout_d;
            overrun_q         <= overrun_d;
        end
    end

    assign mem_start   = mem_start_q;
    assign mem_we      = mem_we_q;
    assign mem_refresh = mem_refresh_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign cpu_ack     = cpu_ack_q;
    assign vid_ack     = vid_ack_q;
    assign dma_ack     = dma_ack_q;
    assign cpu_dout    = cpu_dout_q;
    assign vid_dout    = vid_dout_q;
    assign dma_dout    = dma_dout_q;
    assign overrun     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_slot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_slot_arbiter
//  Purpose  : Directed self-checking bench for mem_slot_arbiter: slot strobe
//             generator, SDRAM response model with per-slot latency, event
//             log, and one task per scenario.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_slot_arbiter;

    localparam int AW = 23;
    localparam int DW = 8;

`ifdef SLOT_DONATE_EN
    localparam int EXP_CPU_STARTS = 31;
    localparam int EXP_VID_LATE   = 9;
    localparam int EXP_DMA_START  = 1;
    localparam int EXP_DMA_SLOT   = 0;
`else
    localparam int EXP_CPU_STARTS = 16;
    localparam int EXP_VID_LATE   = 21;
    localparam int EXP_DMA_START  = 9;
    localparam int EXP_DMA_SLOT   = 2;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          slot_ce = 1'b0;
    logic          frame_sync = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_din = '0;
    logic [DW-1:0] cpu_dout;
    logic          cpu_ack;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic [DW-1:0] vid_dout;
    logic          vid_ack;
    logic          dma_req = 1'b0, dma_we = 1'b0;
    logic [AW-1:0] dma_addr = '0;
    logic [DW-1:0] dma_din = '0;
    logic [DW-1:0] dma_dout;
    logic          dma_ack;
    logic          mem_start, mem_we, mem_refresh;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_done = 1'b0;
    logic          overrun;

    mem_slot_arbiter #(.AW(AW), .DW(DW), .REFRESH_INTERVAL(15)) dut (
        .clk(clk), .reset_n(reset_n), .slot_ce(slot_ce), .frame_sync(frame_sync),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout), .vid_ack(vid_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_din(dma_din),
        .dma_dout(dma_dout), .dma_ack(dma_ack),
        .mem_start(mem_start), .mem_we(mem_we), .mem_refresh(mem_refresh),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_done(mem_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // strobe generator state
    bit gen_en = 1'b0;
    int ce_cnt = 0;
    int cur_slot = 0;
    int n_fs = 0;
    int fs1_cyc = 0;

    // SDRAM model state
    bit         busy = 1'b0;
    int         cnt = 0;
    int         lat0 = 2;
    logic [7:0] rd_val = 8'h00;

    // event log
    int            n_start, n_cpu_ack, n_vid_ack, n_dma_ack, n_ovr, bad_owner;
    int            first_start_cyc, first_start_slot, first_cpu_ack_cyc;
    int            first_ovr_cyc, first_vid_start_cyc, refresh_fs, refresh_slot;
    int            n_own[4];
    logic [AW-1:0] first_start_addr;
    logic          first_start_we;
    logic [DW-1:0] first_start_wdata, ack_cpu_dout;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (!gen_en) begin
            ce_cnt     = 0;
            slot_ce    = 1'b0;
            frame_sync = 1'b0;
        end else begin
            slot_ce    = (ce_cnt % 4 == 0);
            frame_sync = (ce_cnt == 0);
            if (slot_ce) cur_slot = ce_cnt / 4;
            if (frame_sync) begin
                n_fs++;
                if (n_fs == 1) fs1_cyc = cyc;
            end
            ce_cnt = (ce_cnt + 1) % 16;
        end
    end

    initial forever begin
        int own;
        @(negedge clk);
        mem_done  = 1'b0;
        mem_rdata = 8'h00;
        if (busy) begin
            cnt--;
            if (cnt <= 0) begin
                mem_done  = 1'b1;
                mem_rdata = rd_val;
                busy      = 1'b0;
            end
        end
        if (mem_start) begin
            busy = 1'b1;
            cnt  = (cur_slot == 0) ? lat0 : 2;
            own  = mem_refresh ? 3 : (mem_addr == 23'h22 ? 1 : (mem_addr == 23'h33 ? 2 : 0));
            if (n_start == 0) begin
                first_start_cyc   = cyc;
                first_start_slot  = cur_slot;
                first_start_addr  = mem_addr;
                first_start_we    = mem_we;
                first_start_wdata = mem_wdata;
            end
            if (own == 1 && first_vid_start_cyc < 0) first_vid_start_cyc = cyc;
            n_own[own]++;
            if (mem_refresh) begin
                refresh_fs   = n_fs;
                refresh_slot = cur_slot;
            end else if (cur_slot != 3 && own != cur_slot) begin
                bad_owner++;
            end
            n_start++;
        end
        if (cpu_ack) begin
            if (n_cpu_ack == 0) begin
                first_cpu_ack_cyc = cyc;
                ack_cpu_dout      = cpu_dout;
            end
            n_cpu_ack++;
        end
        if (vid_ack) n_vid_ack++;
        if (dma_ack) n_dma_ack++;
        if (overrun) begin
            if (n_ovr == 0) first_ovr_cyc = cyc;
            n_ovr++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        n_start = 0; n_cpu_ack = 0; n_vid_ack = 0; n_dma_ack = 0; n_ovr = 0;
        bad_owner = 0; first_start_cyc = -1; first_start_slot = -1;
        first_cpu_ack_cyc = -1; first_ovr_cyc = -1; first_vid_start_cyc = -1;
        refresh_fs = -1; refresh_slot = -1;
        foreach (n_own[i]) n_own[i] = 0;
        first_start_addr = '0; first_start_we = 1'b0;
        first_start_wdata = '0; ack_cpu_dout = '0;
    endtask

    // Reset the DUT, idle all requesters, then start the strobe generator;
    // the first strobe (slot 0, frame_sync) lands one step later.
    task automatic restart();
        reset_n = 1'b0; gen_en = 1'b0;
        cpu_req = 1'b0; vid_req = 1'b0; dma_req = 1'b0;
        cpu_we = 1'b0; dma_we = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        busy = 1'b0; n_fs = 0; fs1_cyc = 0; lat0 = 2;
        clear_log();
        gen_en = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step();
        checks++;
        if ({mem_start, mem_we, mem_refresh, overrun, cpu_ack, vid_ack, dma_ack} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 0000000",
                     {mem_start, mem_we, mem_refresh, overrun, cpu_ack, vid_ack, dma_ack});
        end
        checks++;
        if (mem_addr !== 23'h0 || mem_wdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_cmd: got addr=%h wdata=%h required 0/0", mem_addr, mem_wdata);
        end
        checks++;
        if ({cpu_dout, vid_dout, dma_dout} !== 24'h0) begin
            errors++;
            $display("FAIL reset_dout: got %h/%h/%h required 0", cpu_dout, vid_dout, dma_dout);
        end
    endtask

    task automatic test_cpu_read();
        restart();
        cpu_addr = 23'h012345; rd_val = 8'hA5; lat0 = 2; cpu_req = 1'b1;
        repeat (24) begin
            step();
            if (cpu_ack) cpu_req = 1'b0;
        end
        checks++;
        if (first_start_cyc !== fs1_cyc + 1) begin
            errors++;
            $display("FAIL cpu_start_time: got cycle %0d required %0d", first_start_cyc, fs1_cyc + 1);
        end
        checks++;
        if (first_start_addr !== 23'h012345 || first_start_we !== 1'b0) begin
            errors++;
            $display("FAIL cpu_cmd: got addr=%h we=%b required 012345/0", first_start_addr, first_start_we);
        end
        checks++;
        if (first_cpu_ack_cyc !== fs1_cyc + 4) begin
            errors++;
            $display("FAIL cpu_ack_time: got cycle %0d required %0d", first_cpu_ack_cyc, fs1_cyc + 4);
        end
        checks++;
        if (ack_cpu_dout !== 8'hA5) begin
            errors++;
            $display("FAIL cpu_dout_at_ack: got %h required a5", ack_cpu_dout);
        end
        checks++;
        if (n_cpu_ack !== 1 || cpu_dout !== 8'hA5) begin
            errors++;
            $display("FAIL cpu_single_ack_hold: got acks=%0d dout=%h required 1/a5", n_cpu_ack, cpu_dout);
        end
    endtask

    task automatic test_all_busy();
        int guard;
        restart();
        cpu_addr = 23'h11; vid_addr = 23'h22; dma_addr = 23'h33;
        cpu_req = 1'b1; vid_req = 1'b1; dma_req = 1'b1;
        guard = 0;
        while (n_fs < 17 && guard < 2000) begin
            step();
            guard++;
        end
        cpu_req = 1'b0; vid_req = 1'b0; dma_req = 1'b0;
        repeat (6) step();
        checks++;
        if (n_own[0] !== EXP_CPU_STARTS || n_own[1] !== 16 || n_own[2] !== 16) begin
            errors++;
            $display("FAIL busy_counts: got cpu=%0d vid=%0d dma=%0d required %0d/16/16",
                     n_own[0], n_own[1], n_own[2], EXP_CPU_STARTS);
        end
        checks++;
        if (bad_owner !== 0) begin
            errors++;
            $display("FAIL busy_order: got %0d misplaced commands required 0", bad_owner);
        end
        checks++;
        if (n_own[3] !== 1 || refresh_fs !== 15 || refresh_slot !== 3) begin
            errors++;
            $display("FAIL busy_refresh: got n=%0d period=%0d slot=%0d required 1/15/3",
                     n_own[3], refresh_fs, refresh_slot);
        end
        checks++;
        if (n_ovr !== 0 || n_vid_ack !== 16 || n_dma_ack !== 16) begin
            errors++;
            $display("FAIL busy_acks: got ovr=%0d vid=%0d dma=%0d required 0/16/16",
                     n_ovr, n_vid_ack, n_dma_ack);
        end
    endtask

    task automatic test_slow_memory();
        restart();
        cpu_addr = 23'h11; vid_addr = 23'h22; rd_val = 8'hC3; lat0 = 6;
        cpu_req = 1'b1; vid_req = 1'b1;
        repeat (40) begin
            step();
            if (cpu_ack) cpu_req = 1'b0;
            if (vid_ack) vid_req = 1'b0;
        end
        checks++;
        if (n_ovr !== 1 || first_ovr_cyc !== fs1_cyc + 5) begin
            errors++;
            $display("FAIL slow_overrun: got n=%0d cycle=%0d required 1/%0d", n_ovr, first_ovr_cyc, fs1_cyc + 5);
        end
        checks++;
        if (first_cpu_ack_cyc !== fs1_cyc + 8) begin
            errors++;
            $display("FAIL slow_cpu_ack: got cycle %0d required %0d", first_cpu_ack_cyc, fs1_cyc + 8);
        end
        checks++;
        if (first_vid_start_cyc !== fs1_cyc + EXP_VID_LATE) begin
            errors++;
            $display("FAIL slow_vid_slot: got cycle %0d required %0d", first_vid_start_cyc, fs1_cyc + EXP_VID_LATE);
        end
        checks++;
        if (n_vid_ack !== 1 || vid_dout !== 8'hC3) begin
            errors++;
            $display("FAIL slow_vid_data: got acks=%0d dout=%h required 1/c3", n_vid_ack, vid_dout);
        end
    endtask

    task automatic test_done_on_slot_edge();
        restart();
        cpu_addr = 23'h11; vid_addr = 23'h22; rd_val = 8'h5A; lat0 = 3;
        cpu_req = 1'b1; vid_req = 1'b1;
        repeat (40) begin
            step();
            if (cpu_ack) cpu_req = 1'b0;
            if (vid_ack) vid_req = 1'b0;
        end
        checks++;
        if (first_cpu_ack_cyc !== fs1_cyc + 5 || ack_cpu_dout !== 8'h5A) begin
            errors++;
            $display("FAIL edge_cpu_ack: got cycle=%0d dout=%h required %0d/5a",
                     first_cpu_ack_cyc, ack_cpu_dout, fs1_cyc + 5);
        end
        checks++;
        if (n_ovr !== 0) begin
            errors++;
            $display("FAIL edge_no_overrun: got %0d pulses required 0", n_ovr);
        end
        checks++;
        if (first_vid_start_cyc !== fs1_cyc + EXP_VID_LATE) begin
            errors++;
            $display("FAIL edge_slot_lost: got vid start %0d required %0d",
                     first_vid_start_cyc, fs1_cyc + EXP_VID_LATE);
        end
    endtask

    task automatic test_donation();
        restart();
        dma_addr = 23'h000100; dma_din = 8'h3C; dma_we = 1'b1; dma_req = 1'b1;
        repeat (24) begin
            step();
            if (dma_ack) dma_req = 1'b0;
        end
        checks++;
        if (first_start_cyc !== fs1_cyc + EXP_DMA_START || first_start_slot !== EXP_DMA_SLOT) begin
            errors++;
            $display("FAIL dma_slot: got cycle=%0d slot=%0d required %0d/%0d",
                     first_start_cyc, first_start_slot, fs1_cyc + EXP_DMA_START, EXP_DMA_SLOT);
        end
        checks++;
        if (first_start_addr !== 23'h000100 || first_start_we !== 1'b1 || first_start_wdata !== 8'h3C) begin
            errors++;
            $display("FAIL dma_cmd: got addr=%h we=%b wdata=%h required 000100/1/3c",
                     first_start_addr, first_start_we, first_start_wdata);
        end
        checks++;
        if (n_dma_ack !== 1 || dma_dout !== 8'h00) begin
            errors++;
            $display("FAIL dma_ack: got acks=%0d dout=%h required 1/00", n_dma_ack, dma_dout);
        end
    endtask

    task automatic test_reset_mid();
        restart();
        cpu_addr = 23'h555; vid_addr = 23'h22; dma_addr = 23'h33; dma_we = 1'b0;
        rd_val = 8'h77; lat0 = 6; cpu_req = 1'b1;
        repeat (4) step();
        checks++;
        if (mem_addr !== 23'h555) begin
            errors++;
            $display("FAIL mid_cmd: got addr=%h required 000555", mem_addr);
        end
        reset_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        checks++;
        if (mem_addr !== 23'h0 || {mem_start, mem_we, mem_refresh, overrun, cpu_ack} !== 5'b0) begin
            errors++;
            $display("FAIL mid_async_clear: got addr=%h flags=%b required 0/00000",
                     mem_addr, {mem_start, mem_we, mem_refresh, overrun, cpu_ack});
        end
        repeat (2) step();
        reset_n = 1'b1;
        clear_log();
        vid_req = 1'b1; dma_req = 1'b1;
        repeat (16) begin
            step();
            if (vid_ack) vid_req = 1'b0;
            if (dma_ack) dma_req = 1'b0;
        end
        checks++;
        if (n_cpu_ack !== 0) begin
            errors++;
            $display("FAIL mid_no_ack: got %0d cpu acks required 0", n_cpu_ack);
        end
        checks++;
        if (first_start_cyc !== fs1_cyc + 9 || first_start_addr !== 23'h22) begin
            errors++;
            $display("FAIL mid_slot_restart: got cycle=%0d addr=%h required %0d/000022",
                     first_start_cyc, first_start_addr, fs1_cyc + 9);
        end
    endtask

    initial begin
        clear_log();
        test_reset();
        test_cpu_read();
        test_all_busy();
        test_slow_memory();
        test_done_on_slot_edge();
        test_donation();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
